// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble, SFD, payload, optional zero pad, CRC-32 FCS, IFG.
// Zero padding to 60 bytes is built only when ETH_TX_PAD_EN is defined.
module eth_tx_framer #(
   parameter int unsigned IFG_BYTES = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] tx_data,
   output logic       tx_en,
   output logic       tx_busy,
   output logic       tx_err
);
   localparam int unsigned PRE_BYTES = 7;
   localparam int unsigned MIN_LEN   = 60;
   localparam int unsigned MAX_LEN   = 1514;
   localparam logic [31:0] POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG} state_t;

   state_t      state;
   logic [10:0] len;
   logic [10:0] len_inc;
   logic [2:0]  step;
   logic [7:0]  ifg_cnt;
   logic [31:0] crc;
   logic [31:0] crc_inv;

   // Reflected CRC-32, one byte processed LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
      end
      return r;
   endfunction

   assign len_inc = (len == 11'h7FF) ? len : len + 11'd1;
   assign crc_inv = ~crc;
   assign s_ready = (state == SFD) || (state == DATA) || (state == DRAIN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx_data <= 8'h00;
         tx_en   <= 1'b0;
         tx_busy <= 1'b0;
         tx_err  <= 1'b0;
         len     <= 11'd0;
         step    <= 3'd0;
         ifg_cnt <= 8'd0;
         crc     <= CRC_INIT;
      end else begin
         tx_err <= 1'b0;
         case (state)
            IDLE: begin
               if (s_valid) begin
                  state   <= PRE;
                  tx_en   <= 1'b1;
                  tx_data <= 8'h55;
                  tx_busy <= 1'b1;
                  step    <= 3'd1;
                  len     <= 11'd0;
               end
            end
            PRE: begin
               if (step == 3'(PRE_BYTES)) begin
                  state   <= SFD;
                  tx_data <= 8'hD5;
                  crc     <= CRC_INIT;
               end else begin
                  tx_data <= 8'h55;
                  step    <= step + 3'd1;
               end
            end
            // The SFD cycle already accepts the first payload byte.
            SFD, DATA: begin
               if (!s_valid || (len_inc > 11'(MAX_LEN))) begin
                  tx_en   <= 1'b0;
                  tx_data <= 8'h00;
                  tx_err  <= 1'b1;
                  ifg_cnt <= 8'd0;
                  state   <= (s_valid && s_last) ? IFG : DRAIN;
               end else begin
                  tx_data <= s_data;
                  crc     <= crc_byte(crc, s_data);
                  len     <= len_inc;
                  step    <= 3'd0;
                  if (s_last) begin
`ifdef ETH_TX_PAD_EN
                     state <= (len_inc < 11'(MIN_LEN)) ? PAD : FCS;
`else
                     state <= FCS;
`endif
                  end else begin
                     state <= DATA;
                  end
               end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
               tx_data <= 8'h00;
               crc     <= crc_byte(crc, 8'h00);
               len     <= len_inc;
               if (len_inc == 11'(MIN_LEN)) state <= FCS;
            end
`endif
            FCS: begin
               tx_data <= crc_inv[{step[1:0], 3'b000} +: 8];
               if (step == 3'd3) begin
                  state   <= IFG;
                  ifg_cnt <= 8'd0;
               end else begin
                  step <= step + 3'd1;
               end
            end
            DRAIN: begin
               if (s_valid && s_last) begin
                  state   <= IFG;
                  ifg_cnt <= 8'd0;
               end
            end
            IFG: begin
               tx_en   <= 1'b0;
               tx_data <= 8'h00;
               if (ifg_cnt == 8'(IFG_BYTES - 1)) begin
                  state   <= IDLE;
                  tx_busy <= 1'b0;
               end else begin
                  ifg_cnt <= ifg_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
